i2s_rx_deser: RTL and testbench

Deserializes the ADC's I2S stream (i_adc_bck / i_adc_lrck / i_adc_adata) into parallel stereo samples in the 50 MHz `clk` domain, directly downstream of the ADC pins and upstream of the DSP datapath. All three I2S inputs are treated as asynchronous and oversampled; no logic runs on `bck`. The block delivers one left/right sample pair per frame with a single-cycle valid strobe and flags malformed frames.

---
 rtl/i2s_rx_deser.sv | 165 ++++++++++++++++
 tb/tb_i2s_rx_deser.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deser.sv
`timescale 1ns/100ps
// Purpose : oversampling I2S receiver; turns the ADC bck/lrck/adata pins into
//           parallel left/right samples in the clk domain, flags bad slot lengths.
// Latency : pin bck rise captured at clk edge N -> outputs updated at edge N+2
//           (visible in cycle N+3); no backpressure, o_valid is a strobe.
// Ports   : clk/rst (sync, active-high); i_bck/i_lrck/i_adata async I2S pins;
//           o_left/o_right sample pair, o_valid + o_frame_err one-cycle strobes,
//           o_locked level while the frame structure is consistent.
module i2s_rx_deser #(
  parameter int DATA_W    = 24,
  parameter int SLOT_W    = 32,
  parameter bit LEFT_LRCK = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_bck,
  input  logic              i_lrck,
  input  logic              i_adata,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic              o_valid,
  output logic              o_frame_err,
  output logic              o_locked
);

  localparam logic [5:0] CNT_MAX  = 6'd63;
  localparam logic [5:0] SLOT_LEN = 6'(SLOT_W);
  localparam logic [5:0] DATA_LEN = 6'(DATA_W);

  // ---------------------------------------------------------------------------
  // Input synchronizers. bck gets a third stage for edge detection; lrck and
  // adata are used from their second stage so they line up with bck_rise.
  // These flops carry no reset: the stored lrck is reloaded from lrck_s2_q
  // during reset, and an unreset bck_s3_q avoids a false rise on reset exit.
  // ---------------------------------------------------------------------------
  logic bck_s1_q, bck_s2_q, bck_s3_q;
  logic lrck_s1_q, lrck_s2_q;
  logic adata_s1_q, adata_s2_q;

  always_ff @(posedge clk) begin
    bck_s1_q   <= i_bck;
    bck_s2_q   <= bck_s1_q;
    bck_s3_q   <= bck_s2_q;
    lrck_s1_q  <= i_lrck;
    lrck_s2_q  <= lrck_s1_q;
    adata_s1_q <= i_adata;
    adata_s2_q <= adata_s1_q;
  end

  // ---------------------------------------------------------------------------
  // Deserializer state
  // ---------------------------------------------------------------------------
  logic              lrck_prev_q, lrck_prev_d;  // lrck at the previous bck rise
  logic [5:0]        cnt_q, cnt_d;              // rises since last boundary (sat.)
  logic              seen_q, seen_d;            // a boundary has occurred since reset
  logic [DATA_W-1:0] shift_q, shift_d;          // current slot, MSB first
  logic [DATA_W-1:0] hold_q, hold_d;            // last good left slot
  logic              hold_vld_q, hold_vld_d;    // hold_q pairs with the coming right
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;

  logic bck_rise;
  logic lrck_change;
  logic ended_left;
  logic slot_good;
  logic in_data;

  assign bck_rise    = bck_s2_q & ~bck_s3_q;
  assign lrck_change = (lrck_s2_q != lrck_prev_q);
  // The slot that closes on a boundary is the one the old lrck level named.
  assign ended_left  = (lrck_prev_q == LEFT_LRCK);
  // The very first boundary after reset closes a partial slot of unknown
  // length, so it can never be judged good.
  assign slot_good   = seen_q && (cnt_q == SLOT_LEN);
  // One-bit I2S delay: the boundary rise (cnt becomes 1) still carries the old
  // slot's bit, so data occupies the rises seen while cnt_q is 1..DATA_W.
  assign in_data     = (cnt_q >= 6'd1) && (cnt_q <= DATA_LEN);

  always_comb begin
    lrck_prev_d = lrck_prev_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    locked_d    = locked_q;

    if (bck_rise) begin
      lrck_prev_d = lrck_s2_q;
      if (lrck_change) begin
        // Slot boundary: judge the slot that just ended.
        cnt_d  = 6'd1;
        seen_d = 1'b1;
        if (slot_good) begin
          if (ended_left) begin
            hold_d     = shift_q;
            hold_vld_d = 1'b1;
          end else if (hold_vld_q) begin
            // A good right slot completes a pair only when its left half
            // survived; otherwise the right data is dropped silently.
            left_d     = hold_q;
            right_d    = shift_q;
            valid_d    = 1'b1;
            locked_d   = 1'b1;
            hold_vld_d = 1'b0;
          end
        end else begin
          err_d      = seen_q;
          locked_d   = 1'b0;
          hold_vld_d = 1'b0;
        end
      end else begin
        // Saturate so a stuck lrck can never wrap back to a legal count.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 6'd1;
        end
        if (in_data) begin
          shift_d = {shift_q[DATA_W-2:0], adata_s2_q};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lrck_prev_q <= lrck_s2_q;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      lrck_prev_q <= lrck_prev_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
    end
  end

  assign o_left      = left_q;
  assign o_right     = right_q;
  assign o_valid     = valid_q;
  assign o_frame_err = err_q;
  assign o_locked    = locked_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
`timescale 1ns/100ps
// Directed bench for i2s_rx_deser: I2S stream with 354 ns bck period driven on
// a half-ns offset grid so pin edges never coincide with clk edges.
module tb_i2s_rx_deser;

  localparam int   DATA_W = 24;
  localparam int   SLOT_W = 32;
  localparam logic LEFT   = 1'b0;
  localparam logic RIGHT  = 1'b1;

  logic              clk = 1'b0;
  logic              rst;
  logic              bck;
  logic              lrck;
  logic              adata;
  logic [DATA_W-1:0] o_left;
  logic [DATA_W-1:0] o_right;
  logic              o_valid;
  logic              o_frame_err;
  logic              o_locked;

  int errors = 0;
  int checks = 0;

  // Strobe monitor: counts pulses and any strobe held longer than one cycle.
  int   valid_cnt = 0;
  int   err_cnt   = 0;
  int   wide_cnt  = 0;
  logic prev_v    = 1'b0;
  logic prev_e    = 1'b0;

  always #10 clk = ~clk;

  i2s_rx_deser #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .LEFT_LRCK(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_bck      (bck),
    .i_lrck     (lrck),
    .i_adata    (adata),
    .o_left     (o_left),
    .o_right    (o_right),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_locked   (o_locked)
  );

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_e = 1'b0;
    end else begin
      if (o_valid) valid_cnt++;
      if (o_frame_err) err_cnt++;
      if ((o_valid && prev_v) || (o_frame_err && prev_e)) wide_cnt++;
      prev_v = o_valid;
      prev_e = o_frame_err;
    end
  end

  // One slot of nper bck periods at lrck level lr. Period 0 is the boundary
  // period (carries the previous slot's trailing bit, sent as 0); periods
  // 1..DATA_W carry smp MSB first; the rest is zero padding.
  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] smp, input int nper);
    for (int p = 0; p < nper; p++) begin
      bck   = 1'b0;
      lrck  = lr;
      adata = (p >= 1 && p <= DATA_W) ? smp[DATA_W-p] : 1'b0;
      #177;
      bck = 1'b1;
      #177;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bck = 1'b0; lrck = RIGHT; adata = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (o_left !== '0) begin errors++; $display("FAIL reset_left: got %h want 000000", o_left); end
    checks++; if (o_right !== '0) begin errors++; $display("FAIL reset_right: got %h want 000000", o_right); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_frame_err); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", o_locked); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #0.5;
  endtask

  task automatic test_nominal;
    send_slot(LEFT,  24'h123456, SLOT_W);  // first boundary, never judged
    send_slot(RIGHT, 24'hABCDEF, SLOT_W);  // left good -> held
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL nom_no_early_valid: got %0d want 0", valid_cnt); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL nom_no_early_lock: got %b want 0", o_locked); end
    send_slot(LEFT,  24'h123456, SLOT_W);  // right slot closes -> first pair
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL nom_first_valid: got %0d want 1", valid_cnt); end
    checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL nom_locked: got %b want 1", o_locked); end
    checks++; if (o_left !== 24'h123456) begin errors++; $display("FAIL nom_left: got %h want 123456", o_left); end
    checks++; if (o_right !== 24'hABCDEF) begin errors++; $display("FAIL nom_right: got %h want abcdef", o_right); end
    send_slot(RIGHT, 24'hABCDEF, SLOT_W);
    send_slot(LEFT,  24'h800000, SLOT_W);
    checks++; if (valid_cnt !== 2) begin errors++; $display("FAIL nom_one_per_frame: got %0d want 2", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL nom_no_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_extremes;
    send_slot(RIGHT, 24'h7FFFFF, SLOT_W);
    send_slot(LEFT,  24'hFFFFFF, SLOT_W);
    checks++; if (o_left !== 24'h800000) begin errors++; $display("FAIL ext_left_min: got %h want 800000", o_left); end
    checks++; if (o_right !== 24'h7FFFFF) begin errors++; $display("FAIL ext_right_max: got %h want 7fffff", o_right); end
    send_slot(RIGHT, 24'h000000, SLOT_W);
    send_slot(LEFT,  24'h123456, SLOT_W);
    checks++; if (o_left !== 24'hFFFFFF) begin errors++; $display("FAIL ext_left_ones: got %h want ffffff", o_left); end
    checks++; if (o_right !== 24'h000000) begin errors++; $display("FAIL ext_right_zero: got %h want 000000", o_right); end
  endtask

  task automatic test_short_slot;
    int v0, e0;
    send_slot(RIGHT, 24'hABCDEF, SLOT_W);
    send_slot(LEFT,  24'h111111, SLOT_W - 1);  // 31-period left slot
    v0 = valid_cnt; e0 = err_cnt;
    send_slot(RIGHT, 24'h222222, SLOT_W);      // short left closes -> error
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL short_err: got %0d want %0d", err_cnt, e0 + 1); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL short_unlock: got %b want 0", o_locked); end
    send_slot(LEFT,  24'h333333, SLOT_W);      // right good but no left pair
    send_slot(RIGHT, 24'h444444, SLOT_W);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL short_no_valid: got %0d want %0d", valid_cnt, v0); end
    send_slot(LEFT,  24'h555555, SLOT_W);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL short_recover: got %0d want %0d", valid_cnt, v0 + 1); end
    checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL short_relock: got %b want 1", o_locked); end
    checks++; if (o_left !== 24'h333333 || o_right !== 24'h444444) begin
      errors++; $display("FAIL short_data: got %h/%h want 333333/444444", o_left, o_right); end
  endtask

  task automatic test_stuck_lrck;
    int v0, e0;
    send_slot(RIGHT, 24'h666666, SLOT_W);
    send_slot(LEFT,  24'h777777, 80);           // lrck stuck for 80 periods
    v0 = valid_cnt; e0 = err_cnt;
    send_slot(RIGHT, 24'h888888, SLOT_W);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL stuck80_err: got %0d want %0d", err_cnt, e0 + 1); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL stuck80_unlock: got %b want 0", o_locked); end
    send_slot(LEFT,  24'h999999, SLOT_W);
    send_slot(RIGHT, 24'hAAAAAA, SLOT_W);
    send_slot(LEFT,  24'hBBBBBB, SLOT_W);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL stuck80_valid: got %0d want %0d", valid_cnt, v0 + 1); end
    // 96 periods: a 6-bit wrapping counter would read 32 here and pass it.
    send_slot(RIGHT, 24'hCCCCCC, 96);
    send_slot(LEFT,  24'hDDDDDD, SLOT_W);
    checks++; if (err_cnt !== e0 + 2) begin errors++; $display("FAIL stuck96_err: got %0d want %0d", err_cnt, e0 + 2); end
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL stuck96_no_valid: got %0d want %0d", valid_cnt, v0 + 1); end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    send_slot(RIGHT, 24'hEEEEEE, SLOT_W);
    send_slot(LEFT,  24'h121212, SLOT_W);       // pair DDDDDD/EEEEEE out
    send_slot(RIGHT, 24'h343434, SLOT_W / 2);   // half a right slot
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (o_left !== '0 || o_right !== '0) begin
      errors++; $display("FAIL mid_rst_data: got %h/%h want 000000/000000", o_left, o_right); end
    checks++; if (o_locked !== 1'b0 || o_valid !== 1'b0 || o_frame_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst_flags: got lock=%b v=%b e=%b want 0", o_locked, o_valid, o_frame_err); end
    rst = 1'b0;
    #0.5;
    v0 = valid_cnt; e0 = err_cnt;
    send_slot(RIGHT, 24'h000000, SLOT_W / 2);
    send_slot(LEFT,  24'h0ABCDE, SLOT_W);       // first boundary after reset
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL mid_rst_no_err: got %0d want %0d", err_cnt, e0); end
    send_slot(RIGHT, 24'h765432, SLOT_W);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL mid_rst_no_valid: got %0d want %0d", valid_cnt, v0); end
    send_slot(LEFT,  24'h000000, SLOT_W);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL mid_rst_valid: got %0d want %0d", valid_cnt, v0 + 1); end
    checks++; if (o_left !== 24'h0ABCDE || o_right !== 24'h765432) begin
      errors++; $display("FAIL mid_rst_data2: got %h/%h want 0abcde/765432", o_left, o_right); end
    checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL mid_rst_lock: got %b want 1", o_locked); end
  endtask

  // N = first clk edge after the pin rise (sync1 captures it). bck_rise is
  // evaluated at edge N+2, so o_valid is high only between edges N+2 and N+3.
  task automatic test_latency;
    send_slot(RIGHT, 24'h13579B, SLOT_W);
    bck = 1'b0; lrck = LEFT; adata = 1'b0;
    #177;
    bck = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_n: got %b want 0", o_valid); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_n1: got %b want 0", o_valid); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL lat_n2: got %b want 1", o_valid); end
    checks++; if (o_left !== 24'h000000 || o_right !== 24'h13579B) begin
      errors++; $display("FAIL lat_data: got %h/%h want 000000/13579b", o_left, o_right); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_n3: got %b want 0", o_valid); end
    #100.5;
    send_slot(LEFT, 24'h000000, 4);
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d wide pulses want 0", wide_cnt); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_extremes;
    test_short_slot;
    test_stuck_lrck;
    test_reset_mid;
    test_latency;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
